seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_MS, default 16: full-frame refresh period in ms.
REQ-002 SHALL have parameter CLK_PER_MS, default 100000: clock cycles per ms (100 MHz).
REQ-003 SHALL have parameter NUM_DIGITS, default 4: digits scanned per frame.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 load_valid  in  1  new display value offered.
REQ-007 load_ready  out  1  value slot free; a transfer occurs on load_valid && load_ready.
REQ-008 value  in  16  four BCD nibbles; [15:12] is digit 0 (leftmost).
REQ-009 dp  in  4  decimal-point enables; bit 3 is digit 0; sampled with value.
REQ-010 lz_en  in  1  leading-zero suppression enable, live.
REQ-011 bright  in  3  brightness 0..7, duty (bright+1)/8.
REQ-012 blank  in  1  force display dark, live.
REQ-013 an  out  4  active-low anodes; digit 0 = 4'b0111 through digit 3 = 4'b1110.
REQ-014 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-015 dp_n  out  1  active-low decimal point.
REQ-016 frame_tick  out  1  one-cycle pulse at each frame boundary.

Function
REQ-017 SLOT = REFRESH_MS*CLK_PER_MS/NUM_DIGITS cycles; SLOT SHALL be a multiple of 8 (elaboration error otherwise).
REQ-018 slot_cnt counts 0..SLOT-1 and wraps; FSM states DIG0..DIG3 advance DIGk->DIGk+1 on slot_cnt==SLOT-1; DIG3 wraps to DIG0.
REQ-019 Frame boundary = last cycle of DIG3; frame_tick SHALL be high exactly on that cycle.
REQ-020 Value buffering: accepted value/dp go into a pending register; load_ready = !pending_full.
REQ-021 At a frame boundary with pending_full, pending SHALL commit to the active register and pending_full SHALL clear; load_ready rises the next cycle.
REQ-022 Accept on the boundary cycle itself (pending empty) SHALL land in pending and commit at the following boundary; the displayed value never changes mid-frame.
REQ-023 PWM: phase = slot_cnt/(SLOT/8); the digit anode is driven low only while phase <= bright; bright sampled at slot_cnt==0 and held for the slot.
REQ-024 Leading-zero suppression (lz_en=1): digit k is dark if nibbles 0..k of the active value are all zero, k<3; digit 3 is never suppressed.
REQ-025 blank=1 SHALL force an=4'b1111 and dp_n=1 while the scan keeps running and frame_tick keeps pulsing.
REQ-026 Decode: nibbles 0-9 give standard patterns; 10-15 give segment g only (7'b0111111).
REQ-027 an, seg and dp_n SHALL be registered, lagging the FSM/slot_cnt by exactly one cycle; at most one anode is low at any time.
REQ-028 Dark digits SHALL drive an=4'b1111 and seg=7'h7F.

Reset
REQ-029 On rst: an=4'b1111, seg=7'h7F, dp_n=1, frame_tick=0, slot_cnt=0, state DIG0, active value=0, dp=0, pending cleared.
REQ-030 load_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-031 rst mid-frame SHALL discard any pending value; rst has priority over load and commit.

Structure
REQ-032 Package seg_scan_pkg SHALL hold the FSM state encoding, the PWM phase count (8), the anode one-cold patterns and the segment constants.
REQ-033 One sub-module, seg7_decode, SHALL be combinational nibble->seg per REQ-026 and instantiated once.

Verification (REFRESH_MS=1, CLK_PER_MS=128 -> SLOT=32, phase=4 cycles)
REQ-034 Reset, then bright=7, load 16'h1234 -> the first frame after commit shows an 0111/1011/1101/1110 for 32 cycles each, with seg patterns for 1, 2, 3, 4.
REQ-035 Load 16'h0057 with lz_en=1 -> digits 0 and 1 dark, digits 2 and 3 show 5 and 7; load 16'h0000 -> only digit 3 lit, showing 0.
REQ-036 Second load_valid while pending_full -> load_ready=0, no transfer; commit at frame_tick, load_ready=1 the next cycle.
REQ-037 bright=1 -> each anode low for 8 of 32 cycles; bright=0 -> low for 4 cycles.
REQ-038 Value 16'hA000, dp=4'b0001 -> digit 0 shows 7'b0111111 and dp_n=0 only on digit 3; blank=1 -> an=4'b1111 while frame_tick still pulses every 128 cycles.
REQ-039 rst asserted in DIG2 with pending_full -> the next cycle has an=4'b1111 and load_ready=1 after release, with active value 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  localparam int unsigned PWM_PHASES = 8;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b0111;
  localparam logic [3:0] AN_DIG1 = 4'b1011;
  localparam logic [3:0] AN_DIG2 = 4'b1101;
  localparam logic [3:0] AN_DIG3 = 4'b1110;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;

  function automatic logic [3:0] an_pattern(input state_t s);
    case (s)
      DIG0:    an_pattern = AN_DIG0;
      DIG1:    an_pattern = AN_DIG1;
      DIG2:    an_pattern = AN_DIG2;
      default: an_pattern = AN_DIG3;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-value load channel: valid/ready handshake carrying BCD value and dp enables.
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] value;
  logic [3:0]  dp;

  modport master (output load_valid, value, dp, input load_ready);
  modport slave  (input load_valid, value, dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous value
// commit, PWM brightness, leading-zero suppression and blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_MS = 16,
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_scan_ctrl_if.slave       load,
  input  logic                 lz_en,
  input  logic [2:0]           bright,
  input  logic                 blank,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic                 dp_n,
  output logic                 frame_tick
);

  localparam int unsigned SLOT   = REFRESH_MS * CLK_PER_MS / NUM_DIGITS;
  localparam int unsigned PH_LEN = SLOT / PWM_PHASES;
  localparam int unsigned SW     = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned PW     = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;

  if (SLOT == 0 || (SLOT % PWM_PHASES) != 0) begin : g_slot_chk
    $error("seg_scan_ctrl: slot length must be a non-zero multiple of 8");
  end
  if (NUM_DIGITS != 4) begin : g_dig_chk
    $error("seg_scan_ctrl: exactly 4 digits are supported");
  end

  state_t      r_state, w_state_nxt;
  logic [SW-1:0] r_slot_cnt;
  logic [PW-1:0] r_ph_cnt;
  logic [2:0]  r_phase;
  logic [2:0]  r_bright;
  logic [2:0]  w_bright_eff;
  logic        w_slot_end, w_ph_end, w_boundary, w_accept;

  logic [15:0] r_pend_val, r_act_val;
  logic [3:0]  r_pend_dp, r_act_dp;
  logic        r_pend_full;

  logic [3:0]  w_nib;
  logic        w_dp_on, w_zero_lead, w_lit;
  logic [6:0]  w_seg_dec;
  logic [3:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dpn_nxt;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp_n;

  assign w_slot_end = (r_slot_cnt == SW'(SLOT - 1));
  assign w_ph_end   = (r_ph_cnt == PW'(PH_LEN - 1));
  assign w_boundary = w_slot_end && (r_state == DIG3);
  assign w_accept   = load.load_valid && !r_pend_full;
  // Brightness is captured on the first cycle of a slot but must already apply there.
  assign w_bright_eff = (r_slot_cnt == '0) ? bright : r_bright;

  assign load.load_ready = !r_pend_full;
  assign frame_tick      = w_boundary;
  assign an              = r_an;
  assign seg             = r_seg;
  assign dp_n            = r_dp_n;

  // PWM phase is tracked by a sub-counter instead of dividing slot_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIG0;
      r_slot_cnt <= '0;
      r_ph_cnt   <= '0;
      r_phase    <= '0;
      r_bright   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + SW'(1);
      r_ph_cnt   <= w_ph_end ? '0 : r_ph_cnt + PW'(1);
      if (w_ph_end) r_phase <= r_phase + 3'd1;
      if (r_slot_cnt == '0) r_bright <= bright;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_slot_end) begin
      case (r_state)
        DIG0:    w_state_nxt = DIG1;
        DIG1:    w_state_nxt = DIG2;
        DIG2:    w_state_nxt = DIG3;
        default: w_state_nxt = DIG0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_act_val   <= '0;
      r_act_dp    <= '0;
    end else if (w_boundary && r_pend_full) begin
      r_act_val   <= r_pend_val;
      r_act_dp    <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_val  <= load.value;
      r_pend_dp   <= load.dp;
      r_pend_full <= 1'b1;
    end
  end

  seg7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_nib       = r_act_val[15:12];
    w_dp_on     = r_act_dp[3];
    w_zero_lead = 1'b0;
    case (r_state)
      DIG0: begin
        w_nib       = r_act_val[15:12];
        w_dp_on     = r_act_dp[3];
        w_zero_lead = (r_act_val[15:12] == '0);
      end
      DIG1: begin
        w_nib       = r_act_val[11:8];
        w_dp_on     = r_act_dp[2];
        w_zero_lead = (r_act_val[15:8] == '0);
      end
      DIG2: begin
        w_nib       = r_act_val[7:4];
        w_dp_on     = r_act_dp[1];
        w_zero_lead = (r_act_val[15:4] == '0);
      end
      default: begin
        w_nib       = r_act_val[3:0];
        w_dp_on     = r_act_dp[0];
        w_zero_lead = 1'b0;
      end
    endcase

    w_lit     = !blank && !(lz_en && w_zero_lead) && (r_phase <= w_bright_eff);
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    w_dpn_nxt = 1'b1;
    if (w_lit) begin
      w_an_nxt  = an_pattern(r_state);
      w_seg_nxt = w_seg_dec;
      w_dpn_nxt = !w_dp_on;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= AN_OFF;
      r_seg  <= SEG_OFF;
      r_dp_n <= 1'b1;
    end else begin
      r_an   <= w_an_nxt;
      r_seg  <= w_seg_nxt;
      r_dp_n <= w_dpn_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SLOT=32 (frame = 128 cycles),
// using a cycle-index reference model of the scan, PWM and load buffering.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lz, bl;
  logic [2:0] br;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n, frame_tick;

  int unsigned total = 0;
  int unsigned bad   = 0;

  seg_scan_ctrl_if lif ();

  seg_scan_ctrl #(
    .REFRESH_MS (1),
    .CLK_PER_MS (128),
    .NUM_DIGITS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif),
    .lz_en      (lz),
    .bright     (br),
    .blank      (bl),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state: m = cycles elapsed since reset release.
  int unsigned m;
  logic [15:0] act_v, pend_v;
  logic [3:0]  act_dp, pend_dp;
  bit          pend_full, accepted;
  logic [2:0]  slot_br;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dpn;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'd0: seg_ref = 7'h40;
      4'd1: seg_ref = 7'h79;
      4'd2: seg_ref = 7'h24;
      4'd3: seg_ref = 7'h30;
      4'd4: seg_ref = 7'h19;
      4'd5: seg_ref = 7'h12;
      4'd6: seg_ref = 7'h02;
      4'd7: seg_ref = 7'h78;
      4'd8: seg_ref = 7'h00;
      4'd9: seg_ref = 7'h10;
      default: seg_ref = 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, m);
    end
  endtask

  task automatic model_reset();
    m = 0; act_v = '0; act_dp = '0; pend_v = '0; pend_dp = '0;
    pend_full = 0; slot_br = '0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1;
  endtask

  // Check current outputs, predict the next registered outputs, advance one cycle.
  task automatic step();
    int unsigned dig, pos, ph;
    logic [15:0] lead;
    logic [3:0]  nib;
    bit          lit;
    chk("an", {12'd0, an}, {12'd0, exp_an});
    chk("seg", {9'd0, seg}, {9'd0, exp_seg});
    chk("dp_n", {15'd0, dp_n}, {15'd0, exp_dpn});
    chk("frame_tick", {15'd0, frame_tick}, {15'd0, (m % 128) == 127});
    chk("load_ready", {15'd0, lif.load_ready}, {15'd0, !pend_full});
    dig = (m / 32) % 4;
    pos = m % 32;
    ph  = pos / 4;
    if (pos == 0) slot_br = br;
    nib  = 4'((act_v >> (4 * (3 - dig))) & 16'hF);
    lead = act_v >> (12 - 4 * dig);
    lit  = !bl && !(lz && dig < 3 && lead == 0) && (ph <= slot_br);
    exp_an  = lit ? ~(4'b1000 >> dig) : 4'hF;
    exp_seg = lit ? seg_ref(nib) : 7'h7F;
    exp_dpn = lit ? !act_dp[3 - dig] : 1'b1;
    accepted = 0;
    if ((m % 128) == 127 && pend_full) begin
      act_v = pend_v; act_dp = pend_dp; pend_full = 0;
    end else if (lif.load_valid && !pend_full) begin
      pend_v = lif.value; pend_dp = lif.dp; pend_full = 1; accepted = 1;
    end
    m++;
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    int unsigned k;
    lif.load_valid = 1'b1; lif.value = v; lif.dp = d;
    k = 0;
    do begin
      step();
      k++;
    end while (!accepted && k < 400);
    lif.load_valid = 1'b0;
    if (!accepted) chk("load_timeout", 16'd1, 16'd0);
  endtask

  task automatic run_to(input int unsigned pos_in_frame);
    for (int unsigned i = 0; i < 128 && (m % 128) != pos_in_frame; i++) step();
  endtask

  task automatic count_frame(output int unsigned lit_cnt, output int unsigned tick_cnt);
    lit_cnt = 0; tick_cnt = 0;
    for (int unsigned i = 0; i < 128; i++) begin
      if (an !== 4'hF) lit_cnt++;
      if (frame_tick === 1'b1) tick_cnt++;
      step();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {9'd0, seg}, 16'h007F);
    chk("rst_dp_n", {15'd0, dp_n}, 16'd1);
    chk("rst_frame_tick", {15'd0, frame_tick}, 16'd0);
    chk("rst_load_ready", {15'd0, lif.load_ready}, 16'd1);
  endtask

  int unsigned nl, nt;

  initial begin
    rst = 1'b1; lz = 1'b0; bl = 1'b0; br = 3'd7;
    lif.load_valid = 1'b0; lif.value = '0; lif.dp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Basic scan of 1234 at full brightness.
    load(16'h1234, 4'h0);
    run(300);

    // Leading-zero suppression.
    lz = 1'b1;
    load(16'h0057, 4'h0);
    run(260);
    load(16'h0000, 4'h0);
    run(260);

    // Accept on the boundary cycle itself, commit one frame later.
    run_to(127);
    load(16'h4321, 4'h0);
    run(260);

    // Second offer while pending is full must wait for the commit.
    lz = 1'b0;
    load(16'h1111, 4'h0);
    load(16'h2222, 4'h0);
    run(260);

    // Brightness duty per frame.
    br = 3'd1;
    run(40);
    count_frame(nl, nt);
    chk("lit_cycles_bright1", 16'(nl), 16'd32);
    chk("ticks_per_frame", 16'(nt), 16'd1);
    br = 3'd0;
    run(40);
    count_frame(nl, nt);
    chk("lit_cycles_bright0", 16'(nl), 16'd16);

    // Non-decimal nibble, decimal point, blanking.
    br = 3'd7;
    load(16'hA000, 4'b0001);
    run(260);
    bl = 1'b1;
    run(10);
    count_frame(nl, nt);
    chk("blank_lit_cycles", 16'(nl), 16'd0);
    chk("blank_ticks_f1", 16'(nt), 16'd1);
    count_frame(nl, nt);
    chk("blank_ticks_f2", 16'(nt), 16'd1);
    bl = 1'b0;

    // Randomized inputs against the model.
    for (int unsigned i = 0; i < 1500; i++) begin
      if ((i % 53) == 0) begin
        br = 3'($urandom_range(0, 7));
        lz = 1'($urandom_range(0, 1));
        bl = ($urandom_range(0, 5) == 0);
      end
      lif.load_valid = ($urandom_range(0, 3) == 0);
      lif.value = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lif.value = lif.value >> (4 * $urandom_range(0, 4));
      lif.dp = 4'($urandom);
      step();
    end
    lif.load_valid = 1'b0;
    bl = 1'b0; br = 3'd7;
    run(300);

    // Reset during DIG2 with a pending value.
    run_to(0);
    load(16'h9876, 4'hF);
    run_to(70);
    chk("pending_before_rst", {15'd0, lif.load_ready}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    model_reset();
    lz = 1'b1;
    run(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
